// File: rtl/pulpissimo_fpga_pkg.sv
// Shared types for the FPGA board-level reset sequencer.
// Holds sequencer state and reset-cause encodings plus default timing constants.
package pulpissimo_fpga_pkg;

    // Sequencer states, from pad release to running SoC.
    typedef enum logic [2:0] {
        S_SYNC,
        S_WAIT_LOCK,
        S_HOLD,
        S_RUN,
        S_SWRST
    } rst_seq_state_e;

    // Cause of the most recent reset, readable by firmware.
    // Encoding 3 is reserved and never produced.
    typedef enum logic [1:0] {
        CAUSE_PAD,
        CAUSE_LOCK,
        CAUSE_SW
    } rst_cause_e;

    localparam int DEF_SYNC_STAGES   = 2;
    localparam int DEF_LOCK_FILTER   = 16;
    localparam int DEF_HOLD_CYCLES   = 1024;
    localparam int DEF_SW_RST_CYCLES = 64;

endpackage

// File: rtl/fpga_reset_sequencer_if.sv
// Board-side bundle between the clock/button logic and the reset sequencer.
// Ports: lock, sw request and boot straps in; SoC reset, ready, straps and cause out.
interface fpga_reset_sequencer_if;

    logic       clk_locked_i;
    logic       sw_rst_req_i;
    logic [1:0] bootsel_i;
    logic       rst_no;
    logic       ready_o;
    logic [1:0] bootsel_o;
    logic [1:0] rst_cause_o;

    // Board side: drives the raw asynchronous inputs, observes the reset outputs.
    modport master (
        output clk_locked_i,
        output sw_rst_req_i,
        output bootsel_i,
        input  rst_no,
        input  ready_o,
        input  bootsel_o,
        input  rst_cause_o
    );

    // Sequencer side.
    modport slave (
        input  clk_locked_i,
        input  sw_rst_req_i,
        input  bootsel_i,
        output rst_no,
        output ready_o,
        output bootsel_o,
        output rst_cause_o
    );

endinterface

// File: rtl/fpga_sync_ff.sv
// Multi-flop synchroniser chain with asynchronous active-high clear.
// Ports: clk, rst (async clear), d (async input), q (synchronised output).
module fpga_sync_ff #(
    parameter int STAGES = 2,
    parameter int WIDTH  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    (* ASYNC_REG = "TRUE" *)
    logic [STAGES-1:0][WIDTH-1:0] chain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/fpga_reset_sequencer.sv
// Board reset sequencer: async assert, sync lock-qualified stretched release of rst_no.
// Ports: ref_clk_i, pad_reset (async, active high), bus (lock/sw/straps in, reset status out).
module fpga_reset_sequencer
    import pulpissimo_fpga_pkg::*;
#(
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int LOCK_FILTER   = DEF_LOCK_FILTER,
    parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int SW_RST_CYCLES = DEF_SW_RST_CYCLES
) (
    input logic                  ref_clk_i,
    input logic                  pad_reset,
    fpga_reset_sequencer_if.slave bus
);

    localparam int FILT_W = $clog2(LOCK_FILTER + 1);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int SW_W   = $clog2(SW_RST_CYCLES + 1);

    localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(LOCK_FILTER - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [SW_W-1:0]   SW_LAST   = SW_W'(SW_RST_CYCLES - 1);

    logic       rel_s;
    logic       lock_s;
    logic       sw_s;
    logic [1:0] boot_s;
    logic       sw_prev_q;
    logic       sw_rise;

    rst_seq_state_e state, state_d;

    logic [FILT_W-1:0] filt_cnt, filt_d;
    logic [HOLD_W-1:0] hold_cnt, hold_d;
    logic [SW_W-1:0]   sw_cnt, sw_d;

    rst_cause_e cause_q, cause_d;
    logic [1:0] boot_q, boot_d;
    logic       rst_no_q;
    logic       ready_q;

    // Pad release is itself synchronised so rst_no can never leave reset
    // on a partial cycle after the button lets go.
    fpga_sync_ff #(.STAGES(SYNC_STAGES), .WIDTH(1)) u_sync_rel (
        .clk (ref_clk_i),
        .rst (pad_reset),
        .d   (1'b1),
        .q   (rel_s)
    );

    fpga_sync_ff #(.STAGES(SYNC_STAGES), .WIDTH(1)) u_sync_lock (
        .clk (ref_clk_i),
        .rst (pad_reset),
        .d   (bus.clk_locked_i),
        .q   (lock_s)
    );

    fpga_sync_ff #(.STAGES(SYNC_STAGES), .WIDTH(1)) u_sync_sw (
        .clk (ref_clk_i),
        .rst (pad_reset),
        .d   (bus.sw_rst_req_i),
        .q   (sw_s)
    );

    fpga_sync_ff #(.STAGES(SYNC_STAGES), .WIDTH(2)) u_sync_boot (
        .clk (ref_clk_i),
        .rst (pad_reset),
        .d   (bus.bootsel_i),
        .q   (boot_s)
    );

    // The previous-value flop runs in every state so a request raised
    // outside S_RUN is consumed there and never fires later.
    assign sw_rise = sw_s & ~sw_prev_q;

    always_ff @(posedge ref_clk_i or posedge pad_reset) begin
        if (pad_reset) begin
            state     <= S_SYNC;
            filt_cnt  <= '0;
            hold_cnt  <= '0;
            sw_cnt    <= '0;
            cause_q   <= CAUSE_PAD;
            boot_q    <= '0;
            rst_no_q  <= 1'b0;
            ready_q   <= 1'b0;
            sw_prev_q <= 1'b0;
        end else begin
            state     <= state_d;
            filt_cnt  <= filt_d;
            hold_cnt  <= hold_d;
            sw_cnt    <= sw_d;
            cause_q   <= cause_d;
            boot_q    <= boot_d;
            rst_no_q  <= (state_d == S_RUN);
            ready_q   <= (state_d == S_RUN);
            sw_prev_q <= sw_s;
        end
    end

    always_comb begin
        state_d = state;
        filt_d  = filt_cnt;
        hold_d  = hold_cnt;
        sw_d    = sw_cnt;
        cause_d = cause_q;
        boot_d  = boot_q;

        unique case (state)
            S_SYNC: begin
                if (rel_s) begin
                    state_d = S_WAIT_LOCK;
                end
            end

            // Any low sample restarts the filter from zero.
            S_WAIT_LOCK: begin
                if (!lock_s) begin
                    filt_d = '0;
                end else if (filt_cnt == FILT_LAST) begin
                    state_d = S_HOLD;
                end else begin
                    filt_d = filt_cnt + FILT_W'(1);
                end
            end

            S_HOLD: begin
                if (!lock_s) begin
                    state_d = S_WAIT_LOCK;
                    cause_d = CAUSE_LOCK;
                end else if (hold_cnt == HOLD_LAST) begin
                    state_d = S_RUN;
                    boot_d  = boot_s;
                end else begin
                    hold_d = hold_cnt + HOLD_W'(1);
                end
            end

            // Lock loss takes priority over a coincident software request.
            S_RUN: begin
                if (!lock_s) begin
                    state_d = S_WAIT_LOCK;
                    cause_d = CAUSE_LOCK;
                end else if (sw_rise) begin
                    state_d = S_SWRST;
                    cause_d = CAUSE_SW;
                end
            end

            // Lock is deliberately not watched here; the filter catches
            // it once the software reset window has elapsed.
            S_SWRST: begin
                if (sw_cnt == SW_LAST) begin
                    state_d = S_WAIT_LOCK;
                end else begin
                    sw_d = sw_cnt + SW_W'(1);
                end
            end

            default: begin
                state_d = S_SYNC;
            end
        endcase

        // Every counter starts from zero in whichever state is entered.
        if (state_d != state) begin
            filt_d = '0;
            hold_d = '0;
            sw_d   = '0;
        end
    end

    assign bus.rst_no      = rst_no_q;
    assign bus.ready_o     = ready_q;
    assign bus.bootsel_o   = boot_q;
    assign bus.rst_cause_o = cause_q;

endmodule

// File: tb/tb_fpga_reset_sequencer.sv
// Directed bench for fpga_reset_sequencer at default parameters.
// Phase table plus hand sequences for exact latencies and async pad assertion.
`timescale 1ns/1ps
module tb_fpga_reset_sequencer;
    import pulpissimo_fpga_pkg::*;

    logic clk = 1'b0;
    logic pad = 1'b1;

    fpga_reset_sequencer_if bus ();

    fpga_reset_sequencer dut (
        .ref_clk_i (clk),
        .pad_reset (pad),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        else
            passed++;
    endtask

    task automatic chk_rng(input string name, input int act,
                           input int lo, input int hi);
        total++;
        if (act < lo || act > hi)
            $display("FAIL %s: got %0d want %0d..%0d", name, act, lo, hi);
        else
            passed++;
    endtask

    // Counts rising edges until rst_no reaches lvl, bounded by maxc.
    task automatic wait_rst(input logic lvl, input int maxc, output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (bus.rst_no !== lvl && n < maxc);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rst_no"}, 32'(bus.rst_no), 0);
        chk({tag, "_ready"}, 32'(bus.ready_o), 0);
        chk({tag, "_bootsel"}, 32'(bus.bootsel_o), 0);
        chk({tag, "_cause"}, 32'(bus.rst_cause_o), 0);
        chk({tag, "_state"}, 32'(dut.state), 32'(S_SYNC));
        chk({tag, "_filt"}, 32'(dut.filt_cnt), 0);
        chk({tag, "_hold"}, 32'(dut.hold_cnt), 0);
        chk({tag, "_swcnt"}, 32'(dut.sw_cnt), 0);
    endtask

    typedef struct {
        logic       pad;
        logic       lock;
        logic       sw;
        logic [1:0] boot;
        int         ncyc;
        logic       rst_no;
        logic       ready;
        logic [1:0] cause;
        logic [1:0] bsel;
    } vec_t;

    vec_t vecs[11];

    initial begin
        int n;
        int bad;

        bus.clk_locked_i = 1'b1;
        bus.sw_rst_req_i = 1'b0;
        bus.bootsel_i    = 2'b10;

        // pad lock sw boot ncyc | rst_no ready cause bootsel
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 2'b10,    5, 1'b0, 1'b0, 2'd0, 2'b00};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 2'b10, 1030, 1'b0, 1'b0, 2'd0, 2'b00};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 2'b10,   20, 1'b1, 1'b1, 2'd0, 2'b10};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 2'b01,   20, 1'b1, 1'b1, 2'd0, 2'b10};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 2'b01,   10, 1'b0, 1'b0, 2'd2, 2'b10};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 2'b01, 1080, 1'b0, 1'b0, 2'd2, 2'b10};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 2'b01,   30, 1'b1, 1'b1, 2'd2, 2'b01};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 2'b01,    5, 1'b0, 1'b0, 2'd1, 2'b01};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 2'b01, 1030, 1'b0, 1'b0, 2'd1, 2'b01};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 2'b01,   30, 1'b1, 1'b1, 2'd1, 2'b01};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 2'b01,    1, 1'b0, 1'b0, 2'd0, 2'b00};

        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            pad              = vecs[i].pad;
            bus.clk_locked_i = vecs[i].lock;
            bus.sw_rst_req_i = vecs[i].sw;
            bus.bootsel_i    = vecs[i].boot;
            repeat (vecs[i].ncyc) @(negedge clk);
            chk($sformatf("v%0d_rst_no", i), 32'(bus.rst_no), 32'(vecs[i].rst_no));
            chk($sformatf("v%0d_ready", i), 32'(bus.ready_o), 32'(vecs[i].ready));
            chk($sformatf("v%0d_cause", i), 32'(bus.rst_cause_o), 32'(vecs[i].cause));
            chk($sformatf("v%0d_bootsel", i), 32'(bus.bootsel_o), 32'(vecs[i].bsel));
        end

        // Exact release latency with lock steady and straps 2'b10.
        @(negedge clk);
        bus.bootsel_i = 2'b10;
        repeat (5) @(negedge clk);
        pad = 1'b0;
        wait_rst(1'b1, 1300, n);
        chk_rng("release_latency", n, 1041, 1043);
        chk("release_ready", 32'(bus.ready_o), 1);
        chk("release_cause", 32'(bus.rst_cause_o), 0);
        chk("release_bootsel", 32'(bus.bootsel_o), 32'(2'b10));

        // Straps change while running: captured value holds.
        @(negedge clk);
        bus.bootsel_i = 2'b01;
        repeat (20) @(negedge clk);
        chk("run_bootsel_stable", 32'(bus.bootsel_o), 32'(2'b10));

        // Software reset: 64 + 16 + 1024 cycles low, new straps captured.
        bus.sw_rst_req_i = 1'b1;
        wait_rst(1'b0, 10, n);
        chk_rng("sw_fall", n, 1, 3);
        chk("sw_cause", 32'(bus.rst_cause_o), 2);
        chk("sw_ready_low", 32'(bus.ready_o), 0);
        wait_rst(1'b1, 1300, n);
        chk_rng("sw_low_len", n, 1103, 1105);
        chk("sw_bootsel", 32'(bus.bootsel_o), 32'(2'b01));
        @(negedge clk);
        bus.sw_rst_req_i = 1'b0;

        // Lock toggling every 8 cycles never qualifies.
        pad              = 1'b1;
        bus.clk_locked_i = 1'b0;
        repeat (3) @(negedge clk);
        pad = 1'b0;
        repeat (10) @(negedge clk);
        bad = 0;
        for (int i = 0; i < 25; i++) begin
            bus.clk_locked_i = i[0];
            repeat (8) begin
                @(negedge clk);
                if (bus.rst_no !== 1'b0) bad++;
            end
        end
        chk("toggle_rst_low", 32'(bad), 0);
        bus.clk_locked_i = 1'b1;
        repeat (17) @(posedge clk);
        #1;
        chk("toggle_not_yet_hold", 32'(dut.state), 32'(S_WAIT_LOCK));
        @(posedge clk);
        #1;
        chk("toggle_hold_entry", 32'(dut.state), 32'(S_HOLD));
        wait_rst(1'b1, 1300, n);
        chk_rng("toggle_hold_len", n, 1023, 1025);

        // One-cycle lock drop in S_RUN, and a sw request raised in S_HOLD.
        @(negedge clk);
        bus.clk_locked_i = 1'b0;
        @(negedge clk);
        bus.clk_locked_i = 1'b1;
        wait_rst(1'b0, 10, n);
        chk_rng("lockdrop_fall", n + 1, 1, 3);
        chk("lockdrop_cause", 32'(bus.rst_cause_o), 1);
        bad = 0;
        repeat (600) begin
            @(negedge clk);
            if (bus.rst_no !== 1'b0) bad++;
        end
        chk("lockdrop_rst_low", 32'(bad), 0);
        chk("lockdrop_in_hold", 32'(dut.state), 32'(S_HOLD));
        bus.sw_rst_req_i = 1'b1;
        wait_rst(1'b1, 1000, n);
        chk_rng("lockdrop_rerelease", n, 440, 442);
        repeat (20) @(negedge clk);
        chk("hold_swreq_ignored", 32'(bus.rst_no), 1);
        chk("hold_swreq_cause", 32'(bus.rst_cause_o), 1);
        bus.sw_rst_req_i = 1'b0;

        // Pad assertion in the middle of S_HOLD.
        @(negedge clk);
        bus.bootsel_i    = 2'b11;
        bus.clk_locked_i = 1'b0;
        @(negedge clk);
        bus.clk_locked_i = 1'b1;
        repeat (320) @(negedge clk);
        chk("midhold_state", 32'(dut.state), 32'(S_HOLD));
        chk("midhold_cause_pre", 32'(bus.rst_cause_o), 1);
        pad = 1'b1;
        #1;
        chk_reset_vals("midhold");

        // Pad assertion in the middle of S_SWRST.
        @(negedge clk);
        pad = 1'b0;
        wait_rst(1'b1, 1300, n);
        chk_rng("midsw_release", n, 1041, 1043);
        chk("midsw_bootsel_pre", 32'(bus.bootsel_o), 32'(2'b11));
        @(negedge clk);
        bus.sw_rst_req_i = 1'b1;
        repeat (33) @(negedge clk);
        chk("midsw_state", 32'(dut.state), 32'(S_SWRST));
        chk("midsw_cause_pre", 32'(bus.rst_cause_o), 2);
        pad = 1'b1;
        #1;
        chk_reset_vals("midsw");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
